// File: rtl/alu_driver_if.sv
// Command/response bus between a stimulus source or controller (master)
// and the ALU command front-end (slave).
interface alu_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_sel;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_err
  );
endinterface

// File: rtl/alu_driver.sv
// Sequential front-end for the combinational 4-bit ALU: accepts one command,
// drives the ALU from registers, captures the 8-bit result one cycle later
// and returns it over a valid/ready response. Keeps an accumulator for
// chained operations and a wrapping count of successful operations.
module alu_driver (
  input  logic               clk,
  input  logic               rst,
  alu_driver_if.slave        bus,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [4:0]         alu_sel,
  input  logic [7:0]         alu_y,
  output logic [7:0]         acc,
  output logic [7:0]         op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state_reg;
  logic [3:0] alu_a_reg;
  logic [3:0] alu_b_reg;
  logic [4:0] alu_sel_reg;
  logic [7:0] rsp_y_reg;
  logic       rsp_err_reg;
  logic       rsp_valid_reg;
  logic [7:0] acc_reg;
  logic [7:0] op_count_reg;

  // Operand A source: low nibble of the previous result when chaining.
  logic [3:0] operand_a_next;
  assign operand_a_next = bus.cmd_use_acc ? acc_reg[3:0] : bus.cmd_a;

  // Ready depends on state only; forced low while reset is held so nothing
  // can be accepted during reset.
  assign bus.cmd_ready = (state_reg == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_y     = rsp_y_reg;
  assign bus.rsp_err   = rsp_err_reg;

  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_sel  = alu_sel_reg;
  assign acc      = acc_reg;
  assign op_count = op_count_reg;

  // Command/response FSM with all outputs registered; reset drops any
  // in-flight command or pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      alu_a_reg     <= 4'd0;
      alu_b_reg     <= 4'd0;
      alu_sel_reg   <= 5'd0;
      rsp_y_reg     <= 8'd0;
      rsp_err_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      acc_reg       <= 8'd0;
      op_count_reg  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_sel[4]) begin
              // Reserved select: answer immediately with an error and leave
              // the ALU operands, accumulator and counter untouched.
              rsp_y_reg     <= 8'd0;
              rsp_err_reg   <= 1'b1;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else begin
              alu_a_reg   <= operand_a_next;
              alu_b_reg   <= bus.cmd_b;
              alu_sel_reg <= bus.cmd_sel;
              state_reg   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // ALU inputs have been stable for a full cycle; capture result.
          rsp_y_reg     <= alu_y;
          acc_reg       <= alu_y;
          rsp_err_reg   <= 1'b0;
          rsp_valid_reg <= 1'b1;
          op_count_reg  <= op_count_reg + 8'd1;
          state_reg     <= RESP;
        end
        RESP: begin
          // A command presented on the retiring edge waits for IDLE.
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: a stand-in ALU, a transaction-level
// reference model, a per-cycle compare process, directed cases with literal
// expectations and a randomized free-running phase.
module tb_alu_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_sel;
  logic [7:0] alu_y;
  logic [7:0] acc;
  logic [7:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  alu_driver_if bus ();

  alu_driver dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_y    (alu_y),
    .acc      (acc),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: signed arithmetic unit (sign-extended) and logic unit.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [4:0] sel);
    int sa;
    int sb;
    int r;
    logic [3:0] l;
    sa = $signed(a);
    sb = $signed(b);
    r = 0;
    l = 4'd0;
    if (!sel[3]) begin
      case (sel[2:0])
        3'd0: r = sa + sb;
        3'd1: r = sa - sb;
        3'd2: r = sb - sa;
        3'd3: r = sa + 1;
        3'd4: r = sa - 1;
        3'd5: r = -sa;
        3'd6: r = sa;
        default: r = sa * sb;
      endcase
      return r[7:0];
    end
    case (sel[2:0])
      3'd0: l = ~a;
      3'd1: l = a | b;
      3'd2: l = a & b;
      3'd3: l = a ^ b;
      3'd4: l = ~(a & b);
      3'd5: l = ~(a | b);
      3'd6: l = ~(a ^ b);
      default: l = b;
    endcase
    return {4'h0, l};
  endfunction

  assign alu_y = alu_fn(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, time-stamped by edge index.
  // m_due is the edge after which the response must be visible.
  bit         m_busy;
  bit         m_err;
  logic [7:0] m_y;
  logic [7:0] m_acc;
  int         m_cnt;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [4:0] m_sel;
  int         m_due;
  int         e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_err = 0; m_y = 8'd0; m_acc = 8'd0; m_cnt = 0;
      m_a = 4'd0; m_b = 4'd0; m_sel = 5'd0; m_due = 0; e = 0;
    end else begin
      e++;
      if (m_busy) begin
        if (!m_err && e == m_due) begin
          m_acc = m_y;
          m_cnt = (m_cnt + 1) % 256;
        end else if (e - 1 >= m_due && bus.rsp_ready) begin
          m_busy = 0;
        end
      end else if (bus.cmd_valid) begin
        m_busy = 1;
        if (bus.cmd_sel[4]) begin
          m_err = 1;
          m_y   = 8'd0;
          m_due = e;
        end else begin
          m_a   = bus.cmd_use_acc ? m_acc[3:0] : bus.cmd_a;
          m_b   = bus.cmd_b;
          m_sel = bus.cmd_sel;
          m_y   = alu_fn(m_a, m_b, m_sel);
          m_err = 0;
          m_due = e + 1;
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
      chk("rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
      chk("rst_rsp_y", bus.rsp_y, 8'd0);
      chk("rst_rsp_err", {7'd0, bus.rsp_err}, 8'd0);
      chk("rst_alu_a", {4'd0, alu_a}, 8'd0);
      chk("rst_alu_b", {4'd0, alu_b}, 8'd0);
      chk("rst_alu_sel", {3'd0, alu_sel}, 8'd0);
      chk("rst_acc", acc, 8'd0);
      chk("rst_op_count", op_count, 8'd0);
    end else begin
      chk("cmd_ready", {7'd0, bus.cmd_ready}, {7'd0, !m_busy});
      chk("rsp_valid", {7'd0, bus.rsp_valid}, {7'd0, (m_busy && e >= m_due)});
      if (m_busy && e >= m_due) begin
        chk("rsp_y", bus.rsp_y, m_y);
        chk("rsp_err", {7'd0, bus.rsp_err}, {7'd0, m_err});
      end
      chk("alu_a", {4'd0, alu_a}, {4'd0, m_a});
      chk("alu_b", {4'd0, alu_b}, {4'd0, m_b});
      chk("alu_sel", {3'd0, alu_sel}, {3'd0, m_sel});
      chk("acc", acc, m_acc);
      chk("op_count", op_count, 8'(m_cnt));
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one command, wait for its response, hold it for 'hold' cycles
  // with rsp_ready low, then retire it. lat counts edges after the accept
  // edge until rsp_valid is seen.
  task automatic send(input logic [4:0] sel, input logic [3:0] a, input logic [3:0] b,
                      input logic ua, input int hold,
                      output logic [7:0] y, output logic err, output int lat);
    int n;
    bus.cmd_sel = sel; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_use_acc = ua;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin step(); n++; end
    chk("cmd_ready_timeout", {7'd0, bus.cmd_ready}, 8'd1);
    step();
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin step(); lat++; end
    chk("rsp_valid_timeout", {7'd0, bus.rsp_valid}, 8'd1);
    y = bus.rsp_y;
    err = bus.rsp_err;
    repeat (hold) step();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] y;
    logic err;
    int lat;
    int n;
    bus.cmd_valid = 1'b0; bus.cmd_sel = 5'd0; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0;
    bus.cmd_use_acc = 1'b0; bus.rsp_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("ready_after_release", {7'd0, bus.cmd_ready}, 8'd1);

    // Add 3+4
    send(5'h00, 4'd3, 4'd4, 1'b0, 0, y, err, lat);
    chk("add_y", y, 8'h07);
    chk("add_err", {7'd0, err}, 8'd0);
    chk("add_latency", 8'(lat), 8'd1);
    chk("add_count", op_count, 8'd1);
    $display("add 3+4 -> y=%0h err=%0b lat=%0d", y, err, lat);

    // Signed multiply and logic AND
    send(5'h07, 4'hE, 4'd3, 1'b0, 0, y, err, lat);
    chk("mul_y", y, 8'hFA);
    $display("mul -2*3 -> y=%0h", y);
    send(5'h0A, 4'hC, 4'hA, 1'b0, 0, y, err, lat);
    chk("and_y", y, 8'h08);
    $display("and C&A -> y=%0h", y);

    // Accumulator chain
    send(5'h00, 4'd3, 4'd4, 1'b0, 0, y, err, lat);
    chk("chain_acc0", acc, 8'h07);
    send(5'h03, 4'd0, 4'd0, 1'b1, 1, y, err, lat);
    chk("chain_alu_a", {4'd0, alu_a}, 8'h07);
    chk("chain_y", y, 8'h08);
    chk("chain_acc1", acc, 8'h08);
    $display("chain inc acc -> y=%0h acc=%0h", y, acc);

    // Reserved select
    send(5'h10, 4'd5, 4'd6, 1'b0, 0, y, err, lat);
    chk("rsv_err", {7'd0, err}, 8'd1);
    chk("rsv_y", y, 8'h00);
    chk("rsv_latency", 8'(lat), 8'd0);
    chk("rsv_count", op_count, 8'd5);
    chk("rsv_acc", acc, 8'h08);
    chk("rsv_alu_sel", {3'd0, alu_sel}, 8'h03);
    $display("reserved sel -> y=%0h err=%0b lat=%0d", y, err, lat);

    // Backpressure with a waiting command
    bus.cmd_sel = 5'h01; bus.cmd_a = 4'd5; bus.cmd_b = 4'd2; bus.cmd_use_acc = 1'b0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_sel = 5'h00; bus.cmd_a = 4'd1; bus.cmd_b = 4'd1;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_y", bus.rsp_y, 8'h03);
      chk("bp_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_ready_after_retire", {7'd0, bus.cmd_ready}, 8'd1);
    step();
    chk("bp_accepted", {7'd0, bus.cmd_ready}, 8'd0);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin step(); n++; end
    chk("bp_second_y", bus.rsp_y, 8'h02);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    $display("backpressure -> second y=%0h", 8'h02);

    // Reset while in ISSUE
    bus.cmd_sel = 5'h00; bus.cmd_a = 4'd1; bus.cmd_b = 4'd2; bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_a", {4'd0, alu_a}, 8'd0);
    chk("mid_rst_acc", acc, 8'd0);
    chk("mid_rst_count", op_count, 8'd0);
    chk("mid_rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("mid_rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {7'd0, bus.cmd_ready}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rsp", {7'd0, bus.rsp_valid}, 8'd0);
    end
    $display("reset in ISSUE -> response dropped");

    // 256 successful operations wrap the counter
    for (int i = 0; i < 256; i++) begin
      send({1'b0, 4'($urandom)}, 4'($urandom), 4'($urandom), 1'($urandom),
           $urandom_range(0, 2), y, err, lat);
      if (i == 254) chk("count_255", op_count, 8'hFF);
    end
    chk("count_wrap", op_count, 8'h00);
    $display("256 ops -> op_count=%0h", op_count);

    // Free-running random traffic including reserved selects
    for (int i = 0; i < 3000; i++) begin
      bus.cmd_valid   = 1'($urandom);
      bus.cmd_sel     = {($urandom_range(0, 7) == 0), 4'($urandom)};
      bus.cmd_a       = 4'($urandom);
      bus.cmd_b       = 4'($urandom);
      bus.cmd_use_acc = 1'($urandom);
      bus.rsp_ready   = 1'($urandom);
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (4) step();
    $display("random phase done, model count=%0d", m_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequential command front-end that drives the combinational 4-bit ALU (`alu`) and returns its results over a valid/ready handshake. It accepts one operation per command, drives the ALU operand/select inputs from registers, and captures the 8-bit result one cycle later. It also maintains an accumulator for chained operations and a completed-operation counter. It sits between a test/stimulus source or a simple controller and the `alu` instance.

## Interface

**Parameters:** none. Widths are fixed by the ALU: 4-bit operands, 5-bit select, 8-bit result.

**Ports**

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_sel` in 5: ALU select.
  - `[2:0]` is the opcode.
  - `[3]` chooses the unit: 0 = arithmetic, 1 = logic.
  - `[4]` is reserved and must be 0.
- `cmd_a` in 4: operand A (signed two's complement).
- `cmd_b` in 4: operand B (signed two's complement).
- `cmd_use_acc` in 1: when 1, operand A is `acc[3:0]` and `cmd_a` is ignored.
- `alu_a` out 4: registered operand A to the ALU.
- `alu_b` out 4: registered operand B to the ALU.
- `alu_sel` out 5: registered select to the ALU.
- `alu_y` in 8: ALU result (combinational from `alu_a`, `alu_b`, `alu_sel`).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_y` out 8: captured result.
- `rsp_err` out 1: response is an error (reserved select).
- `acc` out 8: last successful result.
- `op_count` out 8: number of successful operations, wraps modulo 256.

## Operation

**States:** IDLE, ISSUE, RESP. Reset state is IDLE.

**IDLE**
- `cmd_ready` = 1.
- On `cmd_valid & cmd_ready` with `cmd_sel[4]`=0:
  - Load `alu_a` (either `cmd_a` or `acc[3:0]`), `alu_b` = `cmd_b`, `alu_sel` = `cmd_sel`.
  - Go to ISSUE.
- On `cmd_valid & cmd_ready` with `cmd_sel[4]`=1:
  - Do not load the `alu_*` outputs.
  - Set `rsp_y`=0 and `rsp_err`=1.
  - Go to RESP.

**ISSUE**
- `cmd_ready` = 0.
- At the next edge:
  - Capture `alu_y` into `rsp_y` and `acc`.
  - Set `rsp_err`=0.
  - Increment `op_count` (255→0).
  - Go to RESP.

**RESP**
- `rsp_valid` = 1 and `cmd_ready` = 0.
- `rsp_y` and `rsp_err` stay stable until `rsp_ready` is sampled high; then go to IDLE.

**Handshake rules**
- `cmd_ready` is a function of state only. It never depends combinationally on `cmd_valid`.
- `rsp_valid` is a function of state only.
- `alu_a`, `alu_b` and `alu_sel` hold their last issued values in every state.

**Data rules**
- `acc[3:0]` used as operand A is the low nibble of the last result and is treated as signed 4-bit. Upper bits are discarded.
- Error responses leave `acc`, `op_count` and the `alu_*` outputs unchanged.

**Simultaneous events**
- `rsp_ready` high in RESP together with `cmd_valid` high: the command is not accepted on that edge. It is accepted in IDLE on the following edge.

**Reset (including reset asserted mid-operation)**
- All of the following are 0: `alu_a`, `alu_b`, `alu_sel`, `rsp_y`, `rsp_err`, `acc`, `op_count`, `rsp_valid`.
- `cmd_ready` = 0 while `rst` is high and 1 in the first cycle after release.
- Any in-flight command or pending response is dropped with no response.

## Timing

- **Accept:** a command is accepted at edge N.
  - `alu_*` outputs are valid after N.
  - `rsp_valid` goes high after edge N+1.
  - Minimum command-to-response latency is 2 cycles.
- **Error path:** `rsp_valid` goes high after edge N, i.e. 1 cycle.
- **Throughput:** at most one command per 3 cycles with `rsp_ready` tied high; one per 2 cycles on the error path.
- **ALU path:** the `alu_y` combinational path must settle within one clock period from the `alu_*` registers.

## Test plan

1. Arithmetic add: `cmd_sel`=5'h00, a=3, b=4 → `rsp_y`=8'h07, `rsp_err`=0, `rsp_valid` high 2 cycles after accept, `op_count`=1.
2. Signed multiply and logic op:
   - `cmd_sel`=5'h07, a=4'hE (-2), b=3 → `rsp_y`=8'hFA.
   - `cmd_sel`=5'h0A, a=4'hC, b=4'hA → `rsp_y`=8'h08.
3. Accumulator chain: add 3+4 (`acc`=7), then `cmd_sel`=5'h03 with `cmd_use_acc`=1 and `cmd_a`=0 → `alu_a`=7, `rsp_y`=8'h08, `acc`=8.
4. Reserved select: `cmd_sel`=5'h10 → `rsp_err`=1 and `rsp_y`=0 one cycle after accept; `op_count`, `acc` and `alu_sel` unchanged.
5. Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP while `cmd_valid`=1 → `rsp_y` stable, `cmd_ready`=0 throughout, next command accepted one cycle after `rsp_ready`.
6. Reset and wrap:
   - Assert `rst` in ISSUE → all outputs 0 immediately, no response after release.
   - Run 256 successful operations → `op_count` returns to 0.
